// File: rtl/wb_register_file.sv
// wb_register_file: writeback-stage result mux and 32x32 integer register file
// with a post-reset clear sequencer that zeroes x1..x(NUM_REGS-1), one entry
// per cycle, so the array keeps a single write port.
// Optional feature: define REGFILE_BYPASS_EN for WB->ID write-through on reads.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  CLEAR | zeroing mem[clr_idx] each cycle; init_busy=1, W writes dropped
//  IDLE  | normal operation; W-stage writes commit, reads return array
module wb_register_file #(
    parameter  int NUM_REGS = 32,
    parameter  int XLEN     = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ALU_result_W,
    input  logic [XLEN-1:0] data_memory_RD_W,
    input  logic [AW-1:0]   register_file_WA_W,
    input  logic            ctrl_register_file_WE_W,
    input  logic            ctrl_result_W,
    input  logic [AW-1:0]   register_file_RA1_D,
    input  logic [AW-1:0]   register_file_RA2_D,
    output logic [XLEN-1:0] register_file_RD1_D,
    output logic [XLEN-1:0] register_file_RD2_D,
    output logic [XLEN-1:0] result_W,
    output logic            init_busy
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_idx, clr_idx_nxt;
    logic            arr_we;
    logic [AW-1:0]   arr_wa;
    logic [XLEN-1:0] arr_wd;
    logic            w_commit;
    logic [XLEN-1:0] mem [NUM_REGS];

    assign result_W  = ctrl_result_W ? data_memory_RD_W : ALU_result_W;
    assign init_busy = (state == CLEAR);
    assign w_commit  = ctrl_register_file_WE_W && (register_file_WA_W != '0) && !init_busy;

    // Sequencer state and clear index register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= AW'(1);
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // Next state and the single array write port: sequencer owns it in CLEAR.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        arr_we      = 1'b0;
        arr_wa      = register_file_WA_W;
        arr_wd      = result_W;
        if (!reset) begin
            case (state)
                CLEAR: begin
                    arr_we      = 1'b1;
                    arr_wa      = clr_idx;
                    arr_wd      = '0;
                    clr_idx_nxt = clr_idx + AW'(1);
                    if (clr_idx == AW'(NUM_REGS - 1)) state_nxt = IDLE;
                end
                default: arr_we = w_commit;
            endcase
        end
    end

    // Array storage; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (arr_we) mem[arr_wa] <= arr_wd;
    end

    // Read port 1: x0 and busy force zero, optional same-cycle write-through.
    always_comb begin
        register_file_RD1_D = '0;
        if (!init_busy && register_file_RA1_D != '0) begin
            register_file_RD1_D = mem[register_file_RA1_D];
`ifdef REGFILE_BYPASS_EN
            if (w_commit && register_file_RA1_D == register_file_WA_W)
                register_file_RD1_D = result_W;
`endif
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        register_file_RD2_D = '0;
        if (!init_busy && register_file_RA2_D != '0) begin
            register_file_RD2_D = mem[register_file_RA2_D];
`ifdef REGFILE_BYPASS_EN
            if (w_commit && register_file_RA2_D == register_file_WA_W)
                register_file_RD2_D = result_W;
`endif
        end
    end

endmodule

// File: tb/tb_wb_register_file.sv
// Testbench for wb_register_file: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_wb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu, dmem;
    logic [4:0]  wa, ra1, ra2;
    logic        we, sel;
    logic [31:0] rd1, rd2, res;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents and remaining clear cycles.
    logic [31:0] ref_mem [32];
    int          ref_clear_left = 31;

    wb_register_file #(.NUM_REGS(32), .XLEN(32)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .ALU_result_W            (alu),
        .data_memory_RD_W        (dmem),
        .register_file_WA_W      (wa),
        .ctrl_register_file_WE_W (we),
        .ctrl_result_W           (sel),
        .register_file_RA1_D     (ra1),
        .register_file_RA2_D     (ra2),
        .register_file_RD1_D     (rd1),
        .register_file_RD2_D     (rd2),
        .result_W                (res),
        .init_busy               (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_res();
        return sel ? dmem : alu;
    endfunction

    function automatic logic exp_busy();
        return ref_clear_left > 0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ref_clear_left > 0 || ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa != 5'd0 && ra == wa) return exp_res();
`endif
        return ref_mem[ra];
    endfunction

    // Advance one clock: update the model from the inputs present at the edge.
    task automatic clk_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
            ref_clear_left = 31;
        end else if (ref_clear_left > 0) begin
            ref_clear_left--;
        end else if (we && wa != 5'd0) begin
            ref_mem[wa] = exp_res();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; sel = 0; wa = 0; alu = 0; dmem = 0; ra1 = 0; ra2 = 0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1; idle_inputs(); ra1 = 5; ra2 = 31;
        repeat (3) clk_edge();
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b want=1", busy); end
        checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            errors++; $display("FAIL reset_rd got=%h/%h want=0/0", rd1, rd2);
        end
        reset = 0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin clk_edge(); n++; end
        checks++;
        if (n !== 31) begin errors++; $display("FAIL clear_len got=%0d want=31", n); end
        for (int i = 1; i < 32; i++) begin
            ra1 = 5'(i); #1;
            checks++;
            if (rd1 !== 32'h0) begin errors++; $display("FAIL clear_x%0d got=%h want=0", i, rd1); end
        end
    endtask

    task automatic test_write_read();
        we = 1; wa = 5; sel = 0; alu = 32'hDEADBEEF;
        clk_edge();
        we = 1; wa = 6; sel = 1; dmem = 32'h12345678; alu = 32'h0; ra1 = 5; #1;
        checks++;
        if (res !== 32'h12345678) begin errors++; $display("FAIL result_sel got=%h want=12345678", res); end
        checks++;
        if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_x5 got=%h want=deadbeef", rd1); end
        clk_edge();
        we = 0; ra2 = 6; #1;
        checks++;
        if (rd2 !== 32'h12345678) begin errors++; $display("FAIL rd_x6 got=%h want=12345678", rd2); end
    endtask

    task automatic test_x0();
        we = 1; wa = 0; sel = 0; alu = 32'hFFFFFFFF; ra1 = 0;
        clk_edge();
        we = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rd1 !== 32'h0) begin errors++; $display("FAIL x0_read got=%h want=0", rd1); end
            clk_edge();
        end
    endtask

    task automatic test_raw();
        we = 1; wa = 7; sel = 0; alu = 32'h11;
        clk_edge();
        alu = 32'h22; ra1 = 7; #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (rd1 !== 32'h22) begin errors++; $display("FAIL raw_same got=%h want=22", rd1); end
`else
        if (rd1 !== 32'h11) begin errors++; $display("FAIL raw_same got=%h want=11", rd1); end
`endif
        clk_edge();
        we = 0; #1;
        checks++;
        if (rd1 !== 32'h22) begin errors++; $display("FAIL raw_next got=%h want=22", rd1); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        we = 1; wa = 3; sel = 0; alu = 32'hAA;
        clk_edge();
        we = 0; reset = 1;
        clk_edge();
        reset = 0;
        repeat (10) clk_edge();
        reset = 1;
        clk_edge();
        reset = 0; we = 1; wa = 4; alu = 32'h4444;
        n = 0;
        while (busy === 1'b1 && n < 40) begin clk_edge(); n++; end
        checks++;
        if (n !== 31) begin errors++; $display("FAIL reclear_len got=%0d want=31", n); end
        we = 0; ra1 = 3; ra2 = 4; #1;
        checks++;
        if (rd1 !== 32'h0) begin errors++; $display("FAIL reclear_x3 got=%h want=0", rd1); end
        checks++;
        if (rd2 !== 32'h0) begin errors++; $display("FAIL busy_drop_x4 got=%h want=0", rd2); end
    endtask

    task automatic test_dual_port();
        we = 1; wa = 9; sel = 0; alu = 32'h5A5A5A5A;
        clk_edge();
        we = 0; ra1 = 9; ra2 = 9; #1;
        checks++;
        if (rd1 !== 32'h5A5A5A5A || rd2 !== 32'h5A5A5A5A) begin
            errors++; $display("FAIL dual_port got=%h/%h want=5a5a5a5a", rd1, rd2);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            we    = $urandom_range(0, 3) != 0;
            sel   = 1'($urandom);
            wa    = 5'($urandom);
            ra1   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            ra2   = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom);
            alu   = $urandom;
            dmem  = $urandom;
            #1;
            checks++;
            if (res !== exp_res()) begin errors++; $display("FAIL rnd_res c=%0d got=%h want=%h", c, res, exp_res()); end
            checks++;
            if (busy !== exp_busy()) begin errors++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, exp_busy()); end
            checks++;
            if (rd1 !== exp_rd(ra1)) begin errors++; $display("FAIL rnd_rd1 c=%0d ra=%0d got=%h want=%h", c, ra1, rd1, exp_rd(ra1)); end
            checks++;
            if (rd2 !== exp_rd(ra2)) begin errors++; $display("FAIL rnd_rd2 c=%0d ra=%0d got=%h want=%h", c, ra2, rd2, exp_rd(ra2)); end
            clk_edge();
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_raw();
        test_reset_mid_clear();
        test_dual_port();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
